core_sequencer: RTL
===================

# core_sequencer

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enables the combinational control decoder does not own: instruction-register load, PC update, gated register-file write and data-memory request. It also runs the instruction and data memory handshakes, enforces a data-memory timeout, handles an external pause request and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 16, max cycles in MEM waiting for dmemReady before a bus-error halt (≥1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imemReady  in  1  instruction word valid this cycle.
- dmemReady  in  1  data access completes this cycle.
- decRegfileWrite  in  1  decoder register-file write intent.
- decDmemWrite  in  1  decoder store intent.
- decLoad  in  1  decoder load (write-back selector = DMEM).
- decIllegal  in  1  decoder found an unsupported opcode.
- pauseReq  in  1  external pause request, honoured only at an instruction boundary.
- imemReq  out  1  instruction fetch request.
- irWrite  out  1  load the instruction register.
- dmemReq  out  1  data memory request.
- dmemWrite  out  1  data memory write strobe.
- regfileWrite  out  1  gated register-file write enable.
- pcWrite  out  1  load the next PC.
- paused  out  1  sequencer parked in PAUSE.
- halted  out  1  sequencer in HALT.
- busError  out  1  sticky; HALT was entered by a MEM timeout.
- retiredCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- seqState  out  3  state encoding, for debug.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, PAUSE=6, HALT=7.
- Reset (asynchronous): state=IDLE, retiredCount=0, busError=0, timeout counter=0. All outputs are 0 except seqState=0.
- IDLE: lasts one cycle after reset release, then goes to FETCH.
- FETCH:
  - imemReq=1.
  - When imemReady=1: irWrite=1 in that same cycle, and the next state is DECODE.
  - Otherwise stay in FETCH with no limit.
- DECODE: one cycle for the register-file read. Goes to HALT if decIllegal=1, else EXECUTE.
- EXECUTE: one cycle for the ALU. Goes to MEM if decLoad or decDmemWrite, else WB.
- MEM:
  - dmemReq=1 and dmemWrite=decDmemWrite on every cycle spent in MEM.
  - When dmemReady=1:
    - Load: go to WB.
    - Store: pcWrite=1, retire, then go to FETCH or PAUSE.
  - The timeout counter clears on entry and increments each cycle dmemReady=0.
  - If the counter reaches MEM_TIMEOUT-1 with dmemReady=0: go to HALT, set busError, no retire.
  - dmemReady=1 on the final allowed cycle completes normally.
- WB: regfileWrite=decRegfileWrite, pcWrite=1, retire. Next state is FETCH or PAUSE.
- Retire means retiredCount+1, wrapping from all-ones to 0.
- Pause:
  - pauseReq is sampled only on a retiring cycle.
  - If pauseReq=1 there, the next state is PAUSE instead of FETCH.
  - PAUSE: paused=1, all requests 0. Leaves to FETCH on the first cycle pauseReq=0.
- HALT: terminal, all requests 0, halted=1. Only rst leaves it.
- regfileWrite, dmemWrite and pcWrite are never 1 outside WB/MEM, whatever the decoder drives.
- Decoder inputs are valid from DECODE onward; the sequencer ignores them in IDLE, FETCH, PAUSE and HALT.

## Timing
- All outputs are Moore decodes of the state, except:
  - irWrite = FETCH & imemReady.
  - pcWrite in MEM = store & dmemReady.
  - Retire in MEM is qualified the same way as pcWrite.
- Minimum latency with zero-wait memories, counted from the FETCH cycle to the retire cycle:
  - ALU, branch and jump: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- retiredCount updates on the clock edge that ends the retiring cycle.
- Memory wait states add exactly one cycle each.
- rst asserted mid-instruction:
  - All outputs drop to reset values immediately, with no clock needed.
  - A partial store is not retried; dmemReq deasserts asynchronously.
- pauseReq asserted during a non-retiring cycle has no effect unless it is still high at the retire.

## Test plan
- Zero-wait ALU stream: decRegfileWrite=1 for 3 instructions, imemReady and dmemReady held at 1.
  - seqState sequence 0,1,2,3,5,1,2,3,5,…
  - regfileWrite and pcWrite pulse once per 4 cycles.
  - retiredCount=3 after the 13th cycle following reset release.
- Load with 2 wait states (decLoad=1, dmemReady low for 2 cycles):
  - MEM lasts 3 cycles with dmemReq=1 and dmemWrite=0.
  - Then WB with regfileWrite=1; retire at cycle 7 from FETCH.
- Store with 0 waits and decRegfileWrite=1:
  - dmemWrite=1 in MEM.
  - pcWrite=1 in MEM, with no WB visit and no regfileWrite.
  - retiredCount increments by 1.
- Timeout with MEM_TIMEOUT=4 and dmemReady stuck at 0:
  - HALT reached after 4 MEM cycles, busError=1, halted=1.
  - retiredCount unchanged.
  - A further imemReady pulse causes no change.
- decIllegal=1 in DECODE: next state is HALT, busError=0, and no regfileWrite or pcWrite pulse ever occurs.
- Pause, then reset:
  - pauseReq=1 across a retire: PAUSE entered, paused=1 for as long as pauseReq holds. After release, FETCH follows 1 cycle later.
  - rst asserted in MEM mid-wait: dmemReq=0 combinationally, and retiredCount and busError are 0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Owns IR load, PC update, gated regfile write, data-memory handshake, pause and halt.
module core_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imemReady,
  input  logic             dmemReady,
  input  logic             decRegfileWrite,
  input  logic             decDmemWrite,
  input  logic             decLoad,
  input  logic             decIllegal,
  input  logic             pauseReq,
  output logic             imemReq,
  output logic             irWrite,
  output logic             dmemReq,
  output logic             dmemWrite,
  output logic             regfileWrite,
  output logic             pcWrite,
  output logic             paused,
  output logic             halted,
  output logic             busError,
  output logic [CNT_W-1:0] retiredCount,
  output logic [2:0]       seqState
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_PAUSE   = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           stateQ, stateD;
  logic [TO_W-1:0]  toCntQ, toCntD;
  logic [CNT_W-1:0] retCntQ, retCntD;
  logic             busErrQ, busErrD;
  logic             retire;

  // A store finishes in MEM; loads and ALU ops finish in WB.
  always_comb begin
    stateD  = stateQ;
    toCntD  = toCntQ;
    busErrD = busErrQ;
    retire  = 1'b0;
    case (stateQ)
      S_IDLE:    stateD = S_FETCH;
      S_FETCH:   if (imemReady) stateD = S_DECODE;
      S_DECODE:  stateD = decIllegal ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (decLoad || decDmemWrite) begin
          stateD = S_MEM;
          toCntD = '0;
        end else begin
          stateD = S_WB;
        end
      end
      S_MEM: begin
        if (dmemReady) begin
          if (decDmemWrite) begin
            retire = 1'b1;
            stateD = pauseReq ? S_PAUSE : S_FETCH;
          end else begin
            stateD = S_WB;
          end
        end else if (toCntQ == TO_LAST) begin
          stateD  = S_HALT;
          busErrD = 1'b1;
        end else begin
          toCntD = toCntQ + TO_W'(1);
        end
      end
      S_WB: begin
        retire = 1'b1;
        stateD = pauseReq ? S_PAUSE : S_FETCH;
      end
      S_PAUSE:   if (!pauseReq) stateD = S_FETCH;
      S_HALT:    stateD = S_HALT;
      default:   stateD = S_IDLE;
    endcase
    retCntD = retire ? retCntQ + CNT_W'(1) : retCntQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ  <= S_IDLE;
      toCntQ  <= '0;
      retCntQ <= '0;
      busErrQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      toCntQ  <= toCntD;
      retCntQ <= retCntD;
      busErrQ <= busErrD;
    end
  end

  // Outputs decode the reset-cleared state so they fall asynchronously with rst.
  assign imemReq      = (stateQ == S_FETCH);
  assign irWrite      = (stateQ == S_FETCH) && imemReady;
  assign dmemReq      = (stateQ == S_MEM);
  assign dmemWrite    = (stateQ == S_MEM) && decDmemWrite;
  assign regfileWrite = (stateQ == S_WB) && decRegfileWrite;
  assign pcWrite      = (stateQ == S_WB) || ((stateQ == S_MEM) && decDmemWrite && dmemReady);
  assign paused       = (stateQ == S_PAUSE);
  assign halted       = (stateQ == S_HALT);
  assign busError     = busErrQ;
  assign retiredCount = retCntQ;
  assign seqState     = stateQ;

endmodule
